// File: rtl/plazer_onchip_memory_reader.sv
// Avalon-MM read master: fetches a block of memory words into a small word FIFO and streams them out LSB-first as samples.
// Optional build macro PLAZER_RD_LOOP_EN: repeat the block until stop is asserted.
module plazer_onchip_memory_reader #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 256,
  parameter int SAMPLE_W   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_clken,
  input  logic [DATA_W-1:0]     m_readdata,
  output logic [SAMPLE_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int SPW   = DATA_W / SAMPLE_W;
  localparam int IDX_W = $clog2(SPW);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPW - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
`ifdef PLAZER_RD_LOOP_EN
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
`else
  logic              unused_stop;
  assign unused_stop = stop;
`endif

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];

  logic              issue, last_req, accept, pop, head_last;
  logic [DATA_W-1:0] head_word;
  logic [ADDR_W:0]   start_count;

  // The credit covers the word already in flight, since memory data cannot be back-pressured.
  assign issue       = (state_q == S_FETCH) &&
                       ((fifo_count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
  assign last_req    = (remaining_q == (ADDR_W+1)'(1));
  assign out_valid   = (fifo_count_q != '0);
  assign head_word   = fifo_data[rd_ptr_q];
  assign head_last   = fifo_last[rd_ptr_q];
  assign accept      = out_valid && out_ready;
  assign pop         = accept && (idx_q == IDX_LAST);
  assign start_count = (word_count == '0) ? {1'b1, {ADDR_W{1'b0}}} : word_count;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && last_req;
    wr_ptr_d        = inflight_q ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d        = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_count_d    = fifo_count_q + CNT_W'(inflight_q) - CNT_W'(pop);
    idx_d           = accept ? idx_q + IDX_W'(1) : idx_q;
    done_d          = accept && out_last;
`ifdef PLAZER_RD_LOOP_EN
    base_d          = base_q;
    count_d         = count_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          state_d     = S_FETCH;
          addr_d      = base_addr;
          remaining_d = start_count;
`ifdef PLAZER_RD_LOOP_EN
          base_d      = base_addr;
          count_d     = start_count;
`endif
        end
      end
      S_FETCH: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (last_req) begin
`ifdef PLAZER_RD_LOOP_EN
            if (stop) begin
              state_d = S_DRAIN;
            end else begin
              addr_d      = base_q;
              remaining_d = count_q;
            end
`else
            state_d = S_DRAIN;
`endif
          end
        end
      end
      S_DRAIN: begin
        if (pop && (fifo_count_q == CNT_W'(1)) && !inflight_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_count_q    <= '0;
      idx_q           <= '0;
      done_q          <= 1'b0;
`ifdef PLAZER_RD_LOOP_EN
      base_q          <= '0;
      count_q         <= '0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fifo_count_q    <= fifo_count_d;
      idx_q           <= idx_d;
      done_q          <= done_d;
`ifdef PLAZER_RD_LOOP_EN
      base_q          <= base_d;
      count_q         <= count_d;
`endif
    end
  end

  // NOTE: FIFO storage has no reset; the count and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (inflight_q) begin
      fifo_data[wr_ptr_q] <= m_readdata;
      fifo_last[wr_ptr_q] <= inflight_last_q;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign m_address    = addr_q;
  assign m_chipselect = issue;
  assign m_write      = 1'b0;
  assign m_byteenable = '1;
  assign m_clken      = 1'b1;
  assign out_data     = out_valid ? head_word[idx_q*SAMPLE_W +: SAMPLE_W] : '0;
  assign out_last     = out_valid && head_last && (idx_q == IDX_LAST);

endmodule
